// File: rtl/monster_scheduler.sv
// monster_scheduler: 12-slot monster table feeding state0 of the sprite compositor.
// Slots are walked one per cycle during vblank; spawns come from a Galois LFSR.
module monster_scheduler #(
  parameter int MONSTERS     = 12,
  parameter int SPAWN_PERIOD = 64,
  parameter int HERO_X       = 72,
  parameter int HERO_Y       = 112,
  parameter int HERO_W       = 21,
  parameter int HERO_H       = 15,
  parameter int MONS_W       = 20,
  parameter int MONS_H       = 21,
  parameter int MAX_X        = 145,
  parameter int MAX_Y        = 219,
  parameter int ATK_RANGE    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     frame_tick,
  input  logic                     pressing,
  input  logic [1:0]               hero_dir,
  input  logic                     load_en,
  input  logic [3:0]               load_idx,
  input  logic [18:0]              load_slot,
  output logic [MONSTERS*19-1:0]   state0,
  output logic                     busy,
  output logic                     hero_hit,
  output logic [7:0]               hit_count
);

  localparam int FW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] SPAWN = 2'd2;

  logic [1:0]    st;
  logic [3:0]    idx;
  logic [FW-1:0] frame_cnt;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;

  logic [18:0] cur;
  logic [18:0] scan_slot;
  logic [18:0] spawn_slot;
  logic        kill;
  logic        contact;
  logic        free_found;
  logic [3:0]  free_idx;
  logic [6:0]  p;
  logic [1:0]  ndir;
  int cx, cy, zx0, zx1, zy0, zy1;
  int dx, dy, adx, ady, nx, ny;

  function automatic logic ovl(input int ax, input int ay,
                               input int x0, input int y0,
                               input int x1, input int y1);
    return (ax < x1) && (x0 < ax + MONS_W) &&
           (ay < y1) && (y0 < ay + MONS_H);
  endfunction

  assign busy     = (st != IDLE);
  assign cur      = state0[int'(idx)*19 +: 19];
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
  assign p        = lfsr[14:8];

  always_comb begin
    cx  = int'(cur[10:3]);
    cy  = int'(cur[18:11]);
    zx0 = HERO_X;
    zx1 = HERO_X + HERO_W;
    zy0 = HERO_Y;
    zy1 = HERO_Y + HERO_H;
    // attack strip shares the hero box span on the axis it does not extend
    unique case (hero_dir)
      2'b00: begin zy0 = HERO_Y - ATK_RANGE; zy1 = HERO_Y; end
      2'b01: begin zy0 = HERO_Y + HERO_H; zy1 = zy0 + ATK_RANGE; end
      2'b10: begin zx0 = HERO_X - ATK_RANGE; zx1 = HERO_X; end
      2'b11: begin zx0 = HERO_X + HERO_W; zx1 = zx0 + ATK_RANGE; end
    endcase
    kill    = pressing && ovl(cx, cy, zx0, zy0, zx1, zy1);
    contact = ovl(cx, cy, HERO_X, HERO_Y,
                  HERO_X + HERO_W, HERO_Y + HERO_H);
    dx   = HERO_X - cx;
    dy   = HERO_Y - cy;
    adx  = (dx < 0) ? -dx : dx;
    ady  = (dy < 0) ? -dy : dy;
    nx   = cx;
    ny   = cy;
    ndir = cur[2:1];
    if (dx != 0 || dy != 0) begin
      if (adx >= ady) begin
        nx   = (dx > 0) ? cx + 1 : cx - 1;
        ndir = (dx > 0) ? 2'b11 : 2'b10;
      end else begin
        ny   = (dy > 0) ? cy + 1 : cy - 1;
        ndir = (dy > 0) ? 2'b01 : 2'b00;
      end
    end
    if (nx < 0) nx = 0;
    if (nx > MAX_X) nx = MAX_X;
    if (ny < 0) ny = 0;
    if (ny > MAX_Y) ny = MAX_Y;
    scan_slot = cur;
    if (cur[0]) begin
      if (kill || contact) scan_slot = {cur[18:1], 1'b0};
      else scan_slot = {8'(ny), 8'(nx), ndir, 1'b1};
    end
  end

  always_comb begin
    unique case (lfsr[1:0])
      2'b00: spawn_slot = {8'd0, 1'b0, p, 2'b01, 1'b1};
      2'b01: spawn_slot = {8'(MAX_Y), 1'b0, p, 2'b00, 1'b1};
      2'b10: spawn_slot = {1'b0, p, 8'd0, 2'b11, 1'b1};
      2'b11: spawn_slot = {1'b0, p, 8'(MAX_X), 2'b10, 1'b1};
    endcase
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MONSTERS - 1; i >= 0; i--) begin
      if (!state0[19*i]) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state0    <= '0;
      hero_hit  <= 1'b0;
      hit_count <= 8'd0;
      frame_cnt <= '0;
      st        <= IDLE;
      idx       <= '0;
      lfsr      <= 16'hACE1;
    end else begin
      lfsr     <= lfsr_nxt;
      hero_hit <= 1'b0;
      if (!start) begin
        state0    <= '0;
        hit_count <= 8'd0;
        frame_cnt <= '0;
        st        <= IDLE;
        idx       <= '0;
      end else begin
        unique case (st)
          IDLE: begin
            // a load in the tick cycle swallows the tick
            if (load_en) begin
              if (int'(load_idx) < MONSTERS)
                state0[int'(load_idx)*19 +: 19] <= load_slot;
            end else if (frame_tick) begin
              st  <= SCAN;
              idx <= '0;
            end
          end
          SCAN: begin
            state0[int'(idx)*19 +: 19] <= scan_slot;
            if (cur[0] && kill) begin
              if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            end else if (cur[0] && contact) begin
              hero_hit <= 1'b1;
            end
            if (idx == 4'(MONSTERS - 1)) begin
              idx <= '0;
              if (frame_cnt == FW'(SPAWN_PERIOD - 1)) begin
                frame_cnt <= '0;
                st        <= SPAWN;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
                st        <= IDLE;
              end
            end else begin
              idx <= idx + 4'd1;
            end
          end
          SPAWN: begin
            if (free_found)
              state0[int'(free_idx)*19 +: 19] <= spawn_slot;
            st <= IDLE;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_monster_scheduler.sv
// tb_monster_scheduler: scoreboard bench for monster_scheduler.
// A behavioural model predicts each frame; results are popped when busy drops.
module tb_monster_scheduler;

  localparam int SP = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         frame_tick = 1'b0;
  logic         pressing = 1'b0;
  logic [1:0]   hero_dir = 2'b00;
  logic         load_en = 1'b0;
  logic [3:0]   load_idx = 4'd0;
  logic [18:0]  load_slot = 19'd0;
  logic [227:0] state0;
  logic         busy;
  logic         hero_hit;
  logic [7:0]   hit_count;

  int checks = 0;
  int failures = 0;

  logic [227:0] m_st = '0;
  int           m_hc = 0;
  int           m_fc = 0;
  logic [15:0]  lfsr_m;

  typedef struct {
    logic [227:0] st;
    int hc;
    int hits;
    int busy_n;
  } exp_t;

  exp_t sb[$];

  monster_scheduler #(.SPAWN_PERIOD(SP)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .frame_tick(frame_tick),
    .pressing(pressing),
    .hero_dir(hero_dir),
    .load_en(load_en),
    .load_idx(load_idx),
    .load_slot(load_slot),
    .state0(state0),
    .busy(busy),
    .hero_hit(hero_hit),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_m <= 16'hACE1;
    else lfsr_m <= lstep(lfsr_m);

  task automatic chk(input string tag, input logic [227:0] got,
                     input logic [227:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mslot(input logic [18:0] s, input logic pr,
                       input logic [1:0] d, output logic [18:0] o,
                       output bit k, output bit h);
    int x, y, zx0, zx1, zy0, zy1, dx, dy, nx, ny;
    logic [1:0] nd;
    o = s; k = 0; h = 0;
    if (!s[0]) return;
    x = int'(s[10:3]);
    y = int'(s[18:11]);
    zx0 = 72; zx1 = 93; zy0 = 112; zy1 = 127;
    case (d)
      2'b00: begin zy0 = 104; zy1 = 112; end
      2'b01: begin zy0 = 127; zy1 = 135; end
      2'b10: begin zx0 = 64; zx1 = 72; end
      default: begin zx0 = 93; zx1 = 101; end
    endcase
    if (pr && x < zx1 && x + 20 > zx0 && y < zy1 && y + 21 > zy0) begin
      o[0] = 1'b0; k = 1;
    end else if (x < 93 && x + 20 > 72 && y < 127 && y + 21 > 112) begin
      o[0] = 1'b0; h = 1;
    end else begin
      dx = 72 - x; dy = 112 - y;
      nx = x; ny = y; nd = s[2:1];
      if (dx == 0 && dy == 0) begin
      end else if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy)) begin
        nx = x + ((dx > 0) ? 1 : -1);
        nd = (dx > 0) ? 2'b11 : 2'b10;
      end else begin
        ny = y + ((dy > 0) ? 1 : -1);
        nd = (dy > 0) ? 2'b01 : 2'b00;
      end
      if (nx > 145) nx = 145;
      if (ny > 219) ny = 219;
      if (nx < 0) nx = 0;
      if (ny < 0) ny = 0;
      o = {8'(ny), 8'(nx), nd, 1'b1};
    end
  endtask

  task automatic mspawn(inout logic [227:0] st, input logic [15:0] l);
    logic [7:0] p;
    logic [18:0] v;
    p = {1'b0, l[14:8]};
    case (l[1:0])
      2'b00: v = {8'd0, p, 2'b01, 1'b1};
      2'b01: v = {8'd219, p, 2'b00, 1'b1};
      2'b10: v = {p, 8'd0, 2'b11, 1'b1};
      default: v = {p, 8'd145, 2'b10, 1'b1};
    endcase
    for (int i = 0; i < 12; i++)
      if (!st[19*i]) begin
        st[19*i +: 19] = v;
        break;
      end
  endtask

  task automatic load(input int idx, input int x, input int y,
                      input logic [1:0] d, input logic a);
    load_en = 1'b1;
    load_idx = 4'(idx);
    load_slot = {8'(y), 8'(x), d, a};
    @(negedge clk);
    load_en = 1'b0;
    if (idx < 12 && start) m_st[19*idx +: 19] = load_slot;
  endtask

  task automatic restart();
    start = 1'b0;
    @(negedge clk);
    chk("restart_clear", state0, 0);
    start = 1'b1;
    m_st = '0; m_hc = 0; m_fc = 0;
    @(negedge clk);
  endtask

  task automatic frame(input logic pr, input logic [1:0] d, input bit extra);
    exp_t e;
    logic [18:0] o;
    logic [15:0] l;
    bit k, h, sp;
    int bn, hits, g;
    e.st = m_st; e.hc = m_hc; e.hits = 0;
    for (int i = 0; i < 12; i++) begin
      mslot(e.st[19*i +: 19], pr, d, o, k, h);
      e.st[19*i +: 19] = o;
      if (k && e.hc < 255) e.hc++;
      if (h) e.hits++;
    end
    sp = (m_fc == SP - 1);
    m_fc = sp ? 0 : m_fc + 1;
    e.busy_n = sp ? 13 : 12;
    if (sp) begin
      l = lfsr_m;
      repeat (13) l = lstep(l);
      mspawn(e.st, l);
    end
    sb.push_back(e);
    m_st = e.st; m_hc = e.hc;
    pressing = pr; hero_dir = d;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    bn = 0; hits = 0; g = 0;
    while (busy === 1'b1 && g < 40) begin
      bn++;
      hits += int'(hero_hit);
      if (extra) frame_tick = (bn == 4);
      @(negedge clk);
      g++;
    end
    hits += int'(hero_hit);
    frame_tick = 1'b0;
    e = sb.pop_front();
    chk("busy_len", bn, e.busy_n);
    chk("state0", state0, e.st);
    chk("hit_count", hit_count, e.hc);
    chk("hero_hit_pulses", hits, e.hits);
    if (extra) begin
      repeat (3) @(negedge clk);
      chk("no_rescan", busy, 0);
    end
  endtask

  function automatic int alive_cnt(input logic [227:0] s);
    int n = 0;
    for (int i = 0; i < 12; i++) n += int'(s[19*i]);
    return n;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_state0", state0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_hero_hit", hero_hit, 0);
    rst_n = 1'b1;
    @(negedge clk);
    load(0, 10, 10, 2'b00, 1'b1);
    repeat (2) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      chk("idle_busy", busy, 0);
      @(negedge clk);
    end
    chk("idle_state0", state0, 0);
    start = 1'b1;
    @(negedge clk);

    load(0, 0, 112, 2'b11, 1'b1);
    load(13, 50, 50, 2'b00, 1'b1);
    frame(1'b0, 2'b00, 0);
    chk("move_slot0", state0[18:0], {8'd112, 8'd1, 2'b11, 1'b1});

    load(3, 95, 112, 2'b00, 1'b1);
    frame(1'b1, 2'b11, 0);
    chk("kill_alive", state0[57], 0);
    chk("kill_count", hit_count, 1);

    load(5, 80, 112, 2'b00, 1'b1);
    frame(1'b0, 2'b00, 0);
    chk("contact_alive", state0[95], 0);
    chk("contact_count", hit_count, 1);

    restart();
    frame(1'b0, 2'b00, 0);
    frame(1'b0, 2'b00, 0);
    chk("spawn_alive", state0[0], 1);
    restart();
    for (int i = 0; i < 12; i++) load(i, i, 0, 2'b00, 1'b1);
    frame(1'b0, 2'b00, 0);
    frame(1'b0, 2'b00, 0);
    chk("full_alive", alive_cnt(state0), 12);

    frame(1'b0, 2'b00, 1);
    load_en = 1'b1;
    load_idx = 4'd2;
    load_slot = {8'd30, 8'd40, 2'b00, 1'b1};
    frame_tick = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    frame_tick = 1'b0;
    m_st[38 +: 19] = {8'd30, 8'd40, 2'b00, 1'b1};
    chk("tick_load_busy", busy, 0);
    chk("tick_load_slot", state0, m_st);

    restart();
    repeat (23) begin
      for (int i = 0; i < 12; i++) load(i, 95, 112, 2'b00, 1'b1);
      frame(1'b1, 2'b11, 0);
    end
    chk("sat_count", hit_count, 255);

    load(0, 5, 5, 2'b00, 1'b1);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (6) @(negedge clk);
    chk("mid_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_state0", state0, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_hit_count", hit_count, 0);
    chk("mid_rst_hero_hit", hero_hit, 0);
    m_st = '0; m_hc = 0; m_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(4, 0, 112, 2'b00, 1'b1);
    frame(1'b0, 2'b00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
